// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle MIPS-subset core (IF/ID/EXE/MEM/WB) with one req/ready memory port.
// Define MC_CPU_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module mc_cpu_core #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] curPC,
  output logic [2:0]        status,
  output logic              retire,
  output logic              halted
`ifdef MC_CPU_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, pc4, br_pc, j_pc;
  logic [31:0]       ir, a, b, alu_out, mdr, alu_res, wb_data;
  logic [31:0]       regs [32];
  logic              retire_q, retire_next;
  logic              ld_ir, ld_ab, ld_alu, ld_mdr, pc_we, rf_we;
  logic              funct_ok, op_known;
  logic signed [31:0] br_off;
  logic [4:0]        wb_dest;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  assign pc4    = pc + ADDR_W'(4);
  assign br_off = {{14{imm[15]}}, imm, 2'b00};
  assign br_pc  = pc4 + ADDR_W'(br_off);
  assign j_pc   = (pc4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({target, 2'b00});

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL);
  assign op_known = ((op == OP_RTYPE) && funct_ok) || (op == OP_ADDI) || (op == OP_ORI) ||
                    (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);

  assign wb_dest = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = a + b;
          FN_SUB:  alu_res = a - b;
          FN_AND:  alu_res = a & b;
          FN_OR:   alu_res = a | b;
          FN_SLT:  alu_res = {31'b0, ($signed(a) < $signed(b))};
          FN_SLL:  alu_res = b << shamt;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a + {{16{imm[15]}}, imm};
      OP_ORI:                alu_res = a | {16'b0, imm};
      OP_BEQ, OP_BNE:        alu_res = a - b;
      default:               alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IF;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ld_ir       = 1'b0;
    ld_ab       = 1'b0;
    ld_alu      = 1'b0;
    ld_mdr      = 1'b0;
    pc_we       = 1'b0;
    pc_next     = pc4;
    rf_we       = 1'b0;
    retire_next = 1'b0;
    case (state)
      S_IF: begin
        if (mem_ready) begin
          ld_ir      = 1'b1;
          state_next = S_ID;
        end
      end
      S_ID: begin
        ld_ab = 1'b1;
        if (op == OP_J) begin
          pc_we       = 1'b1;
          pc_next     = j_pc;
          retire_next = 1'b1;
          state_next  = S_IF;
        end else if (op == OP_HALT) begin
          state_next = S_HALT;
        end else if (!op_known) begin
          pc_we       = 1'b1;
          retire_next = 1'b1;
          state_next  = S_IF;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        ld_alu = 1'b1;
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_we       = 1'b1;
          pc_next     = (((a == b) ? 1'b1 : 1'b0) == (op == OP_BEQ)) ? br_pc : pc4;
          retire_next = 1'b1;
          state_next  = S_IF;
        end else if (op == OP_LW || op == OP_SW) begin
          // A misaligned effective address stops the core before any request goes out.
          state_next = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_we       = 1'b1;
            retire_next = 1'b1;
            state_next  = S_IF;
          end else begin
            ld_mdr     = 1'b1;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        pc_we       = 1'b1;
        retire_next = 1'b1;
        state_next  = S_IF;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      retire_q <= 1'b0;
    end else begin
      if (ld_ir)  ir <= mem_rdata;
      if (ld_ab) begin
        a <= regs[rs];
        b <= regs[rt];
      end
      if (ld_alu) alu_out <= alu_res;
      if (ld_mdr) mdr <= mem_rdata;
      if (pc_we)  pc <= pc_next;
      retire_q <= retire_next;
    end
  end

  // Register 0 is never written, so it always reads back as zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (wb_dest != 5'd0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Request outputs decode from registered state only; RST gating drops the request at once on reset.
  assign mem_req   = RST && ((state == S_IF) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && (op == OP_SW);
  assign mem_addr  = (state == S_MEM) ? ADDR_W'(alu_out) : pc;
  assign mem_wdata = b;
  assign curPC     = pc;
  assign status    = state;
  assign retire    = retire_q;
  assign halted    = (state == S_HALT);

`ifdef MC_CPU_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire_q)        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb_mc_cpu_core: directed tests for mc_cpu_core with a configurable wait-state memory model.
module tb_mc_cpu_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, curPC;
  logic [2:0]  status;
  logic        retire, halted;
`ifdef MC_CPU_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 CLK = ~CLK;

  mc_cpu_core dut (
    .CLK(CLK), .RST(RST),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .curPC(curPC), .status(status), .retire(retire), .halted(halted)
`ifdef MC_CPU_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  int errors = 0;
  int checks = 0;

  // Program memory is loaded by the tests; DUT stores land in wmem tagged with the current generation.
  logic [31:0] pmem [256];
  logic [31:0] wmem [256];
  int          wgen [256];
  int          cur_gen = 0;
  int          wait_cfg = 0;

  int          wait_cnt = 0, req_len = 0;
  int          stable_errs = 0, we_errs = 0, len_errs = 0;
  logic        in_req = 1'b0, hold_we;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] fetch_q[$], wr_addr_q[$], wr_data_q[$];

  int          retire_at[$];
  int          fetch_base, wr_base, stable_base, we_base, len_base;

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    return (wgen[addr[9:2]] == cur_gen) ? wmem[addr[9:2]] : pmem[addr[9:2]];
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, shamt, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'b000010, t};
  endfunction

  // Memory responder: grants after wait_cfg request cycles and watches request stability.
  always @(negedge CLK) begin
    mem_ready = 1'b0;
    if (mem_req !== 1'b1) begin
      wait_cnt = 0;
      in_req   = 1'b0;
      req_len  = 0;
    end else begin
      if (in_req) begin
        if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) stable_errs++;
      end else begin
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
        in_req     = 1'b1;
      end
      req_len++;
      if (mem_we === 1'b1 && status !== 3'b011) we_errs++;
      if (wait_cnt >= wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = rd_word(mem_addr);
        if (mem_we === 1'b1) begin
          wmem[mem_addr[9:2]] = mem_wdata;
          wgen[mem_addr[9:2]] = cur_gen;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else if (status === 3'b000) begin
          fetch_q.push_back(mem_addr);
        end
        if (req_len != wait_cfg + 1) len_errs++;
        wait_cnt = 0;
        in_req   = 1'b0;
        req_len  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic hold_reset(input int waits);
    RST = 1'b0;
    wait_cfg = waits;
    cur_gen++;
    for (int i = 0; i < 256; i++) pmem[i] = 32'hA5A5_A5A5;
    repeat (2) @(posedge CLK);
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    fetch_base  = fetch_q.size();
    wr_base     = wr_addr_q.size();
    stable_base = stable_errs;
    we_base     = we_errs;
    len_base    = len_errs;
    retire_at.delete();
    RST = 1'b1;
  endtask

  task automatic run_until_halt(input int max_cycles);
    int cyc = 0;
    while (cyc < max_cycles && halted !== 1'b1) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (retire === 1'b1) retire_at.push_back(cyc);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_timeout: halted=%b after %0d cycles, expected 1", halted, cyc);
    end
  endtask

  task automatic test_reset();
    hold_reset(0);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (status !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b expected 000", status); end
    checks++; if (curPC !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", curPC); end
    checks++; if (retire !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: retire=%b halted=%b expected 0 0", retire, halted);
    end
  endtask

  task automatic test_zero_wait();
    hold_reset(0);
    pmem[0] = enc_i(ADDI, 0, 1, 16'd5);
    pmem[1] = enc_i(ADDI, 0, 2, 16'hFFFD);
    pmem[2] = enc_r(1, 2, 3, 0, 6'b100000);
    pmem[3] = enc_i(SW, 0, 3, 16'h0080);
    pmem[4] = HALT;
    release_reset();
    run_until_halt(200);
    checks++; if (retire_at.size() != 4) begin errors++; $display("[TB] FAIL zw_retires: got %0d expected 4", retire_at.size()); end
    checks++; if (retire_at.size() < 3 || retire_at[2] != 12) begin
      errors++; $display("[TB] FAIL zw_cycles: third retire at %0d expected 12", (retire_at.size() < 3) ? -1 : retire_at[2]);
    end
    checks++; if (rd_word(32'h80) !== 32'h2) begin errors++; $display("[TB] FAIL zw_r3: got %h expected 00000002", rd_word(32'h80)); end
    checks++; if (curPC !== 32'h10 || status !== 3'b111) begin
      errors++; $display("[TB] FAIL zw_halt: pc=%h status=%b expected 00000010 111", curPC, status);
    end
  endtask

  task automatic test_wait_states();
    hold_reset(3);
    pmem[0]  = enc_i(LW, 0, 4, 16'h0040);
    pmem[1]  = enc_i(SW, 0, 4, 16'h0084);
    pmem[2]  = HALT;
    pmem[16] = 32'hDEAD_BEEF;
    release_reset();
    run_until_halt(400);
    checks++; if (retire_at.size() < 1 || retire_at[0] != 11) begin
      errors++; $display("[TB] FAIL ws_lw_cycles: got %0d expected 11", (retire_at.size() < 1) ? -1 : retire_at[0]);
    end
    checks++; if (rd_word(32'h84) !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL ws_r4: got %h expected deadbeef", rd_word(32'h84));
    end
    checks++; if (stable_errs != stable_base) begin
      errors++; $display("[TB] FAIL ws_stable: %0d unstable request cycles, expected 0", stable_errs - stable_base);
    end
    checks++; if (len_errs != len_base) begin
      errors++; $display("[TB] FAIL ws_req_len: %0d requests not 4 cycles long, expected 0", len_errs - len_base);
    end
  endtask

  task automatic test_store_load();
    hold_reset(0);
    pmem[0]  = enc_j(26'h40);
    pmem[64] = enc_i(ADDI, 0, 3, 16'd2);
    pmem[65] = enc_i(SW, 0, 3, 16'h0008);
    pmem[66] = enc_i(LW, 0, 5, 16'h0008);
    pmem[67] = enc_i(SW, 0, 5, 16'h0084);
    pmem[68] = HALT;
    release_reset();
    run_until_halt(200);
    checks++; if (retire_at.size() < 1 || retire_at[0] != 2) begin
      errors++; $display("[TB] FAIL sl_j_cycles: got %0d expected 2", (retire_at.size() < 1) ? -1 : retire_at[0]);
    end
    checks++; if (wr_addr_q.size() < wr_base + 1 || wr_addr_q[wr_base] !== 32'h8 || wr_data_q[wr_base] !== 32'h2) begin
      errors++; $display("[TB] FAIL sl_first_write: writes=%0d expected addr 00000008 data 00000002", wr_addr_q.size() - wr_base);
    end
    checks++; if (we_errs != we_base) begin errors++; $display("[TB] FAIL sl_we_state: %0d cycles with we outside MEM, expected 0", we_errs - we_base); end
    checks++; if (rd_word(32'h84) !== 32'h2) begin errors++; $display("[TB] FAIL sl_r5: got %h expected 00000002", rd_word(32'h84)); end
    checks++; if (retire_at.size() < 4 || retire_at[2] - retire_at[1] != 4 || retire_at[3] - retire_at[2] != 5) begin
      errors++; $display("[TB] FAIL sl_mem_cycles: sw/lw retire spacing wrong, expected 4 and 5");
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [2] = '{BEQ, BNE};
    logic [31:0] want [2] = '{32'h1C, 32'h14};
    for (int k = 0; k < 2; k++) begin
      hold_reset(0);
      pmem[0] = enc_i(ADDI, 0, 1, 16'd7);
      pmem[1] = enc_i(ADDI, 0, 2, 16'd7);
      pmem[2] = enc_i(ADDI, 0, 3, 16'd1);
      pmem[3] = enc_i(ADDI, 0, 4, 16'd1);
      pmem[4] = enc_i(ops[k], 1, 2, 16'd2);
      pmem[5] = HALT;
      pmem[6] = HALT;
      pmem[7] = HALT;
      release_reset();
      run_until_halt(200);
      checks++; if (fetch_q.size() < fetch_base + 6 || fetch_q[fetch_base + 5] !== want[k]) begin
        errors++; $display("[TB] FAIL br_next_fetch_%0d: got %h expected %h", k,
                           (fetch_q.size() < fetch_base + 6) ? 32'hFFFF_FFFF : fetch_q[fetch_base + 5], want[k]);
      end
      checks++; if (curPC !== want[k]) begin errors++; $display("[TB] FAIL br_halt_pc_%0d: got %h expected %h", k, curPC, want[k]); end
      checks++; if (retire_at.size() < 5 || retire_at[4] - retire_at[3] != 3) begin
        errors++; $display("[TB] FAIL br_cycles_%0d: branch did not take 3 cycles", k);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] want [8] = '{32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'h1, 32'h0, 32'h50, 32'h0000_FFF5, 32'h0};
    hold_reset(0);
    pmem[0]  = enc_i(ADDI, 0, 1, 16'hFFFD);
    pmem[1]  = enc_i(ADDI, 0, 2, 16'd5);
    pmem[2]  = enc_r(1, 2, 3, 0, 6'b100010);
    pmem[3]  = enc_r(1, 2, 4, 0, 6'b100100);
    pmem[4]  = enc_r(1, 2, 5, 0, 6'b100101);
    pmem[5]  = enc_r(1, 2, 6, 0, 6'b101010);
    pmem[6]  = enc_r(2, 1, 7, 0, 6'b101010);
    pmem[7]  = enc_r(0, 2, 8, 4, 6'b000000);
    pmem[8]  = enc_i(ORI, 2, 9, 16'hFFF0);
    pmem[9]  = 32'hF800_0000;
    pmem[10] = enc_r(1, 1, 0, 0, 6'b100000);
    for (int k = 0; k < 7; k++) pmem[11 + k] = enc_i(SW, 0, 5'(3 + k), 16'(32'h80 + 4 * k));
    pmem[18] = enc_i(SW, 0, 0, 16'h009C);
    pmem[19] = HALT;
    release_reset();
    run_until_halt(400);
    for (int k = 0; k < 8; k++) begin
      checks++; if (rd_word(32'h80 + 4 * k) !== want[k]) begin
        errors++; $display("[TB] FAIL alu_result_%0d: got %h expected %h", k, rd_word(32'h80 + 4 * k), want[k]);
      end
    end
    checks++; if (retire_at.size() != 19) begin errors++; $display("[TB] FAIL alu_retires: got %0d expected 19", retire_at.size()); end
  endtask

  task automatic test_misaligned();
    int bad = 0;
    hold_reset(0);
    pmem[0] = enc_i(LW, 0, 4, 16'd2);
    pmem[1] = HALT;
    release_reset();
    run_until_halt(50);
    checks++; if (status !== 3'b111 || halted !== 1'b1) begin
      errors++; $display("[TB] FAIL mis_halt: status=%b halted=%b expected 111 1", status, halted);
    end
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (mem_req !== 1'b0 || retire !== 1'b0 || status !== 3'b111 || curPC !== 32'h0) bad++;
    end
    checks++; if (bad != 0 || fetch_q.size() != fetch_base + 1 || retire_at.size() != 0) begin
      errors++; $display("[TB] FAIL mis_frozen: bad=%0d fetches=%0d retires=%0d expected 0 1 0", bad, fetch_q.size() - fetch_base, retire_at.size());
    end
  endtask

  task automatic test_reset_mid();
    hold_reset(20);
    pmem[0] = enc_j(26'h40);
    release_reset();
    repeat (30) @(posedge CLK);
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || curPC !== 32'h100) begin
      errors++; $display("[TB] FAIL rm_pending: req=%b addr=%h pc=%h expected 1 00000100 00000100", mem_req, mem_addr, curPC);
    end
    #2 RST = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || curPC !== 32'h0 || status !== 3'b000) begin
      errors++; $display("[TB] FAIL rm_async: req=%b pc=%h status=%b expected 0 00000000 000", mem_req, curPC, status);
    end
    release_reset();
    @(posedge CLK);
    #1;
    checks++; if (status !== 3'b000 || curPC !== 32'h0 || mem_addr !== 32'h0) begin
      errors++; $display("[TB] FAIL rm_after: status=%b pc=%h addr=%h expected 000 00000000 00000000", status, curPC, mem_addr);
    end
  endtask

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_store_load();
    test_branch();
    test_alu();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
